// File: rtl/iob_cache_pkg.sv
// iob_cache_pkg: shared address-field widths, FSM state codes and the invalidate control address
package iob_cache_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int NLINES_W = 4;
  localparam int WORD_OFFSET_W = 2;
  localparam int B = DATA_W / 8;
  localparam int BO = $clog2(B);
  localparam int WA = ADDR_W - 1 - BO;
  localparam int AW = ADDR_W - BO;
  localparam int IDX_W = NLINES_W;
  localparam int TAG_W = WA - NLINES_W - WORD_OFFSET_W;
  localparam int NLINES = 2 ** NLINES_W;
  localparam int WPL = 2 ** WORD_OFFSET_W;
  localparam int CNT_W = WORD_OFFSET_W + 1;
  localparam logic [WA-1:0] INV_ADDR = WA'(10);
  typedef logic [2:0] state_t;
  localparam state_t IDLE     = 3'd0;
  localparam state_t READ_ACK = 3'd1;
  localparam state_t FILL     = 3'd2;
  localparam state_t WRITE    = 3'd3;
  localparam state_t CTRL_ACK = 3'd4;
endpackage

// File: rtl/iob_cache_mem_model.sv
// iob_cache_mem_model: byte-writable synchronous backing RAM with one-cycle read latency
module iob_cache_mem_model
  import iob_cache_pkg::*;
(
  input  logic              clk_i,
  input  logic [B-1:0]      we_i,
  input  logic [WA-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem [2**WA];
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < B; b++)
      if (we_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    rdata_o <= mem[addr_i];
  end
endmodule

// File: rtl/iob_cache_wrapper.sv
// iob_cache_wrapper: direct-mapped write-through, no-write-allocate cache over an internal RAM
module iob_cache_wrapper
  import iob_cache_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [B-1:0]      wstrb_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ack_o
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NLINES-1:0] valid_q, valid_d;
  logic ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, wdata_q, ram_rdata;
  logic [WA-1:0] waddr_q, ram_addr;
  logic [B-1:0] wstrb_q, ram_we;
  logic [TAG_W-1:0] tag_arr [NLINES];
  logic [DATA_W-1:0] data_arr [NLINES*WPL];
  logic [TAG_W-1:0] in_tag, tag_q;
  logic [IDX_W-1:0] in_idx, idx_q;
  logic [WORD_OFFSET_W-1:0] off_q, fill_off;
  logic in_ctrl, in_hit, q_hit, wr_go;
  assign in_ctrl = addr_i[AW-1];
  assign in_tag = addr_i[WA-1 -: TAG_W];
  assign in_idx = addr_i[WORD_OFFSET_W +: IDX_W];
  assign in_hit = valid_q[in_idx] && tag_arr[in_idx] == in_tag;
  assign {tag_q, idx_q, off_q} = waddr_q;
  assign q_hit = valid_q[idx_q] && tag_arr[idx_q] == tag_q;
  // RAM data lags its address by one cycle, so fill writes trail the read counter by one
  assign fill_off = WORD_OFFSET_W'(cnt_q - 1'b1);
  assign wr_go = state_q == WRITE && !cnt_q[0];
  assign ram_addr = state_q == FILL ? {tag_q, idx_q, cnt_q[WORD_OFFSET_W-1:0]} : waddr_q;
  assign ram_we = wr_go ? wstrb_q : '0;
  assign ack_o = ack_q;
  assign rdata_o = rdata_q;

  iob_cache_mem_model u_mem (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    valid_d = valid_q;
    ack_d = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req_i) begin
        state_d = in_ctrl ? CTRL_ACK : |wstrb_i ? WRITE : in_hit ? READ_ACK : FILL;
        cnt_d = '0;
        if (!in_ctrl && wstrb_i == '0 && !in_hit) valid_d[in_idx] = 1'b0;
      end
      READ_ACK: begin
        ack_d = 1'b1;
        rdata_d = data_arr[{idx_q, off_q}];
        state_d = IDLE;
      end
      FILL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WPL)) begin
          valid_d[idx_q] = 1'b1;
          state_d = READ_ACK;
        end
      end
      WRITE: begin
        cnt_d = cnt_q + 1'b1;
        ack_d = cnt_q[0];
        state_d = cnt_q[0] ? IDLE : WRITE;
      end
      CTRL_ACK: begin
        ack_d = 1'b1;
        rdata_d = '0;
        valid_d = waddr_q == INV_ADDR ? '0 : valid_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      valid_q <= '0;
      ack_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      ack_q <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && req_i) begin
      waddr_q <= addr_i[WA-1:0];
      wdata_q <= wdata_i;
      wstrb_q <= wstrb_i;
    end
    if (state_q == FILL && cnt_q != '0) data_arr[{idx_q, fill_off}] <= ram_rdata;
    if (state_q == FILL && cnt_q == CNT_W'(WPL)) tag_arr[idx_q] <= tag_q;
    if (wr_go && q_hit)
      for (int b = 0; b < B; b++)
        if (wstrb_q[b]) data_arr[{idx_q, off_q}][8*b +: 8] <= wdata_q[8*b +: 8];
  end
endmodule

// File: tb/tb_iob_cache_wrapper.sv
// tb_iob_cache_wrapper: directed vector table plus hand sequences for reset-abort and back-to-back
module tb_iob_cache_wrapper;
  import iob_cache_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [B-1:0] wstrb = '0;
  logic [DATA_W-1:0] rdata;
  logic ack;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DATA_W-1:0] d;
    logic [B-1:0] s;
    logic [DATA_W-1:0] er;
    int el;
    bit rd;
  } vec_t;
  vec_t v[$];

  iob_cache_wrapper dut (
    .clk_i   (clk),
    .reset_i (reset),
    .req_i   (req),
    .addr_i  (addr),
    .wdata_i (wdata),
    .wstrb_i (wstrb),
    .rdata_o (rdata),
    .ack_o   (ack)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic add(input logic [AW-1:0] a, input logic [DATA_W-1:0] d, input logic [B-1:0] s,
                     input logic [DATA_W-1:0] er, input int el);
    vec_t x;
    x.a = a; x.d = d; x.s = s; x.er = er; x.el = el;
    x.rd = s == '0;
    v.push_back(x);
  endtask

  // one transaction: lat counts edges from acceptance to the edge raising ack, -1 on timeout
  task automatic xact(input logic [AW-1:0] a, input logic [DATA_W-1:0] d, input logic [B-1:0] s,
                      output logic [DATA_W-1:0] r, output logic [DATA_W-1:0] r2,
                      output logic a2, output int lat);
    @(negedge clk);
    req = 1'b1; addr = a; wdata = d; wstrb = s;
    lat = -1; r = '0;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ack) begin
        lat = k - 1;
        r = rdata;
        break;
      end
      addr = ~a; wdata = ~d; wstrb = ~s;
    end
    req = 1'b0; wstrb = '0;
    @(negedge clk);
    a2 = ack;
    r2 = rdata;
  endtask

  initial begin
    logic [DATA_W-1:0] r, r2;
    logic a2;
    int lat, acks;
    for (int i = 0; i < 5; i++) add(AW'(i), DATA_W'(3 * i), 4'hF, 0, 2);
    add(10'h000, 0, 4'h0, 32'd0, 6);
    add(10'h001, 0, 4'h0, 32'd3, 1);
    add(10'h002, 0, 4'h0, 32'd6, 1);
    add(10'h003, 0, 4'h0, 32'd9, 1);
    add(10'h004, 0, 4'h0, 32'd12, 6);
    add(10'h000, 32'h0000DEAD, 4'hF, 0, 2);
    add(10'h000, 0, 4'h0, 32'h0000DEAD, 1);
    add(10'h005, 32'hAABBCCDD, 4'hF, 0, 2);
    add(10'h005, 32'h00000011, 4'h1, 0, 2);
    add(10'h005, 0, 4'h0, 32'hAABBCC11, 1);
    add(10'h014, 32'hAABBCCDD, 4'hF, 0, 2);
    add(10'h014, 32'h00000011, 4'h1, 0, 2);
    add(10'h014, 0, 4'h0, 32'hAABBCC11, 6);
    add(10'h20A, 0, 4'h0, 32'd0, 1);
    add(10'h000, 0, 4'h0, 32'h0000DEAD, 6);
    add(10'h20B, 0, 4'h0, 32'd0, 1);
    add(10'h000, 0, 4'h0, 32'h0000DEAD, 1);
    add(10'h200, 32'hFFFFFFFF, 4'hF, 0, 1);
    add(10'h000, 0, 4'h0, 32'h0000DEAD, 1);
    add(10'h040, 32'h12345678, 4'hF, 0, 2);
    add(10'h040, 0, 4'h0, 32'h12345678, 6);
    add(10'h000, 0, 4'h0, 32'h0000DEAD, 6);
    add(10'h001, 0, 4'h0, 32'd3, 1);

    repeat (2) @(negedge clk);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    reset = 1'b0;

    foreach (v[i]) begin
      xact(v[i].a, v[i].d, v[i].s, r, r2, a2, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(v[i].el));
      check($sformatf("v%0d_ack_pulse", i), 32'(a2), 32'd0);
      if (v[i].rd) begin
        check($sformatf("v%0d_rdata", i), r, v[i].er);
        check($sformatf("v%0d_rdata_hold", i), r2, v[i].er);
      end
    end

    // write with the dependent read presented during the write's ack cycle
    @(negedge clk);
    req = 1'b1; addr = 10'h000; wdata = 32'h00000055; wstrb = 4'hF;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack) begin
        lat = k;
        break;
      end
    end
    check("b2b_write_ack", 32'(lat >= 0), 32'd1);
    wstrb = '0;
    @(negedge clk);
    check("b2b_gap", 32'(ack), 32'd0);
    @(negedge clk);
    check("b2b_read_ack", 32'(ack), 32'd1);
    check("b2b_read_data", rdata, 32'h00000055);
    req = 1'b0;

    // reset in the middle of a line fill
    xact(10'h20A, 0, 4'h0, r, r2, a2, lat);
    check("inv_latency", 32'(lat), 32'd1);
    @(negedge clk);
    req = 1'b1; addr = 10'h014; wstrb = '0;
    @(posedge clk);
    acks = 0;
    repeat (2) @(negedge clk) acks += int'(ack);
    reset = 1'b1; req = 1'b0;
    repeat (2) @(negedge clk) acks += int'(ack);
    check("midfill_reset_rdata", rdata, 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk) acks += int'(ack);
    check("midfill_no_ack", 32'(acks), 32'd0);
    xact(10'h014, 0, 4'h0, r, r2, a2, lat);
    check("post_reset_latency", 32'(lat), 32'd6);
    check("post_reset_rdata", r, 32'hAABBCC11);
    xact(10'h015, 32'h0BADF00D, 4'hF, r, r2, a2, lat);
    xact(10'h015, 0, 4'h0, r, r2, a2, lat);
    check("post_reset_hit_latency", 32'(lat), 32'd1);
    check("post_reset_hit_rdata", r, 32'h0BADF00D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/iob_cache_wrapper.md
# iob_cache_wrapper

Self-contained cache subsystem: a direct-mapped, write-through, no-write-allocate data cache in front of an internal backing RAM, exposed through one IOb-native slave port. Sits between a CPU-side requester and a memory model so the cache can be exercised stand-alone. The address MSB selects a control space used for cache invalidation.

## Interface
- ADDR_W, 12: byte-address width including the control bit; bit ADDR_W-1 is ctrl.
- DATA_W, 32: data width; byte count B = DATA_W/8, BO = log2(B).
- NLINES_W, 4: log2 of the number of cache lines.
- WORD_OFFSET_W, 2: log2 of words per line.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  request valid; held until ack.
- addr  in  ADDR_W-BO  {ctrl, word address}; word address width WA = ADDR_W-1-BO.
- wdata  in  DATA_W  write data.
- wstrb  in  B  byte write enables; all zero means read.
- rdata  out  DATA_W  read data, valid while ack=1.
- ack  out  1  one-cycle completion pulse.

## Operation
- Word address split: tag = addr[WA-1:NLINES_W+WORD_OFFSET_W], index = next NLINES_W bits, word offset = low WORD_OFFSET_W bits.
- Storage: per-line valid bit, tag register, data array of 2^(NLINES_W+WORD_OFFSET_W) words with byte enables; backing RAM of 2^WA words, byte-writable, synchronous, 1-cycle read latency, contents undefined until written.
- FSM states: IDLE, READ_ACK, FILL, WRITE, CTRL_ACK.
- IDLE, req=1, ctrl=0, wstrb=0, hit (valid && tag match): go READ_ACK; rdata = cached word.
- IDLE, read miss: go FILL; fetch all 2^WORD_OFFSET_W words of the line from RAM, word 0 first, one word per cycle; then write tag, set valid, go READ_ACK returning the requested word.
- IDLE, wstrb≠0: go WRITE; write wdata under wstrb to RAM; if hit, also update the cached word under wstrb; miss leaves the cache unchanged.
- IDLE, ctrl=1: go CTRL_ACK; word address 10 clears all valid bits; any other control address is a no-op; rdata=0, and writes are ignored.
- Every *_ACK/WRITE completion asserts ack for exactly one cycle, then returns to IDLE.
- Request fields are sampled at acceptance in IDLE and held in registers; changes to addr/wdata/wstrb after acceptance are ignored.
- rdata holds its last value when ack=0.

## Timing
- Reset values: ack=0, rdata=0, all valid bits 0, FSM in IDLE; RAM and data array not cleared.
- Reset mid-transaction: aborts immediately, no ack produced; a partially filled line stays invalid.
- Latency, counted from the edge that samples req in IDLE to the edge that raises ack: read hit 1; write 2; control 1; read miss 2^WORD_OFFSET_W+2 (4 fill reads plus a 1-cycle RAM latency plus the ack cycle).
- Handshake: the requester drops req or presents a new request during the ack cycle. req=1 in the cycle after ack is a new request.
- Back-to-back: one transaction in flight; the next is accepted in the cycle after ack at the earliest.
- Write-then-read of the same address returns the new data, whether the line was resident or not.

## Structure
- Shared package holds the address-field width constants (BO, WA, tag width, index width), the FSM state enum and the invalidate control address (10).
- One natural sub-module is iob_cache_mem_model, the byte-writable synchronous backing RAM. Cache arrays and the FSM stay in the top module.

## Test plan
- Write words 0..4 with wdata = 3·i, full wstrb, then read 0..4. Each read returns 0,3,6,9,12; the first read misses and fills the line, and later reads within that line hit with latency 1.
- Read word 0 to make it resident, write 0xDEAD to word 0, then read word 0. The read returns 0xDEAD with hit latency 1.
- Write 0xAABBCCDD, then write 0x11 with wstrb=0001, then read. The read returns 0xAABBCC11.
- Read word 0 (resident), issue a control access to address 10, then read word 0 again. The second read is a miss (latency 6) and returns the RAM data.
- Write word 4·2^NLINES_W, which has the same index as word 0 and a different tag, then read it, then read word 0. Both reads return the correct data and each read misses.
- Assert reset during a FILL. No ack is produced, and a subsequent read of the same address misses and returns the correct data.
